// File: rtl/mem_usage_pkg.sv
// Shared types and defaults for the buffer-occupancy report path.
package mem_usage_pkg;
   localparam int         USAGE_W_DEFAULT = 16;
   localparam logic [7:0] HDR_TAG_DEFAULT = 8'hA5;
   localparam int         DROP_W          = 8;

   typedef enum logic [1:0] {
      IDLE,
      SEND_HDR,
      SEND_MAX,
      SEND_MIN
   } rpt_state_t;
endpackage

// File: rtl/window_extrema.sv
// Window counter with peak (and, under MEM_REPORT_MIN_EN, minimum) trackers.
// The snapshots include the current sample, so the window-end cycle is counted exactly once.
module window_extrema #(
   parameter int USAGE_W       = 16,
   parameter int WINDOW_CYCLES = 1024
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               window_en,
   input  logic [USAGE_W-1:0] sample,
   output logic               win_end,
   output logic [USAGE_W-1:0] peak_snap
`ifdef MEM_REPORT_MIN_EN
   ,
   output logic [USAGE_W-1:0] min_snap
`endif
);
   localparam int                CNT_W    = $clog2(WINDOW_CYCLES);
   localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(WINDOW_CYCLES - 1);

   logic [CNT_W-1:0]   count;
   logic [USAGE_W-1:0] peak;

   assign win_end   = window_en && (count == LAST_CNT);
   assign peak_snap = (sample > peak) ? sample : peak;

   // Trackers clear at window end so the following sample seeds the next window.
   always_ff @(posedge clk) begin
      if (reset || !window_en || win_end) begin
         count <= '0;
         peak  <= '0;
      end else begin
         count <= count + 1'b1;
         peak  <= peak_snap;
      end
   end

`ifdef MEM_REPORT_MIN_EN
   logic [USAGE_W-1:0] min_val;

   assign min_snap = (sample < min_val) ? sample : min_val;

   always_ff @(posedge clk) begin
      if (reset || !window_en || win_end) begin
         min_val <= '1;
      end else begin
         min_val <= min_snap;
      end
   end
`endif
endmodule

// File: rtl/mem_usage_reporter.sv
// Emits one report frame (HDR, MAX[, MIN]) per occupancy window on a valid/ready stream.
// Define MEM_REPORT_MIN_EN to add the per-window minimum as a third word.
module mem_usage_reporter
   import mem_usage_pkg::*;
#(
   parameter int         USAGE_W       = USAGE_W_DEFAULT,
   parameter int         WINDOW_CYCLES = 1024,
   parameter logic [7:0] HDR_TAG       = HDR_TAG_DEFAULT
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [USAGE_W-1:0] current_mem_usage,
   input  logic               window_en,
   output logic [USAGE_W-1:0] rpt_data,
   output logic               rpt_valid,
   input  logic               rpt_ready,
   output logic               rpt_last,
   output logic [DROP_W-1:0]  drop_cnt
);
   rpt_state_t         state;
   logic               win_end;
   logic [USAGE_W-1:0] peak_snap;
   logic [USAGE_W-1:0] rep_max;
   logic [7:0]         seq;
   logic [USAGE_W-1:0] hdr_word;

   assign hdr_word = USAGE_W'({HDR_TAG, seq});

`ifdef MEM_REPORT_MIN_EN
   logic [USAGE_W-1:0] min_snap;
   logic [USAGE_W-1:0] rep_min;
`endif

   window_extrema #(
      .USAGE_W       (USAGE_W),
      .WINDOW_CYCLES (WINDOW_CYCLES)
   ) u_extrema (
      .clk       (clk),
      .reset     (reset),
      .window_en (window_en),
      .sample    (current_mem_usage),
      .win_end   (win_end),
      .peak_snap (peak_snap)
`ifdef MEM_REPORT_MIN_EN
      ,
      .min_snap  (min_snap)
`endif
   );

   // A window ending while a frame is in flight (including its final accept cycle) is dropped.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         rpt_valid <= 1'b0;
         rpt_last  <= 1'b0;
         rpt_data  <= '0;
         drop_cnt  <= '0;
         seq       <= '0;
         rep_max   <= '0;
`ifdef MEM_REPORT_MIN_EN
         rep_min   <= '1;
`endif
      end else begin
         if (win_end) begin
            if (state == IDLE) begin
               rep_max   <= peak_snap;
`ifdef MEM_REPORT_MIN_EN
               rep_min   <= min_snap;
`endif
               state     <= SEND_HDR;
               rpt_valid <= 1'b1;
               rpt_data  <= hdr_word;
               rpt_last  <= 1'b0;
            end else if (drop_cnt != '1) begin
               drop_cnt <= drop_cnt + 1'b1;
            end
         end
         if (rpt_valid && rpt_ready) begin
            case (state)
               SEND_HDR: begin
                  state    <= SEND_MAX;
                  rpt_data <= rep_max;
`ifdef MEM_REPORT_MIN_EN
                  rpt_last <= 1'b0;
`else
                  rpt_last <= 1'b1;
`endif
               end
`ifdef MEM_REPORT_MIN_EN
               SEND_MAX: begin
                  state    <= SEND_MIN;
                  rpt_data <= rep_min;
                  rpt_last <= 1'b1;
               end
               SEND_MIN: begin
                  state     <= IDLE;
                  rpt_valid <= 1'b0;
                  rpt_last  <= 1'b0;
                  seq       <= seq + 1'b1;
               end
`else
               SEND_MAX: begin
                  state     <= IDLE;
                  rpt_valid <= 1'b0;
                  rpt_last  <= 1'b0;
                  seq       <= seq + 1'b1;
               end
`endif
               default: ;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_mem_usage_reporter.sv
// Directed bench: a 4-cycle-window instance for framing/drop/reset cases and a
// 1024-cycle-window instance for the long back-pressure case.
module tb_mem_usage_reporter;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] a_usage = '0;
   logic        a_en = 1'b0;
   logic        a_ready = 1'b1;
   logic [15:0] a_data;
   logic        a_valid;
   logic        a_last;
   logic [7:0]  a_drop;
   logic [15:0] b_usage = '0;
   logic        b_en = 1'b0;
   logic        b_ready = 1'b0;
   logic [15:0] b_data;
   logic        b_valid;
   logic        b_last;
   logic [7:0]  b_drop;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   mem_usage_reporter #(.USAGE_W(16), .WINDOW_CYCLES(4), .HDR_TAG(8'hA5)) dut_a (
      .clk               (clk),
      .reset             (reset),
      .current_mem_usage (a_usage),
      .window_en         (a_en),
      .rpt_data          (a_data),
      .rpt_valid         (a_valid),
      .rpt_ready         (a_ready),
      .rpt_last          (a_last),
      .drop_cnt          (a_drop)
   );

   mem_usage_reporter #(.USAGE_W(16), .WINDOW_CYCLES(1024), .HDR_TAG(8'hA5)) dut_b (
      .clk               (clk),
      .reset             (reset),
      .current_mem_usage (b_usage),
      .window_en         (b_en),
      .rpt_data          (b_data),
      .rpt_valid         (b_valid),
      .rpt_ready         (b_ready),
      .rpt_last          (b_last),
      .drop_cnt          (b_drop)
   );

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [15:0] s);
      a_usage = s;
      tick();
   endtask

   initial begin
      tick();
      tick();
      checkOutput("rst_valid", 32'(a_valid), 32'd0);
      checkOutput("rst_last",  32'(a_last),  32'd0);
      checkOutput("rst_data",  32'(a_data),  32'd0);
      checkOutput("rst_drop",  32'(a_drop),  32'd0);
      reset = 1'b0;

      // basic frame, samples 3,9,2,5
      a_en = 1'b1;
      a_ready = 1'b1;
      applyStimulus(16'd3);
      applyStimulus(16'd9);
      applyStimulus(16'd2);
      checkOutput("t1_no_early_valid", 32'(a_valid), 32'd0);
      applyStimulus(16'd5);
      checkOutput("t1_hdr_valid", 32'(a_valid), 32'd1);
      checkOutput("t1_hdr",       32'(a_data),  32'h0000A500);
      checkOutput("t1_hdr_last",  32'(a_last),  32'd0);
      applyStimulus(16'd7);
      checkOutput("t1_max", 32'(a_data), 32'h9);
`ifdef MEM_REPORT_MIN_EN
      checkOutput("t1_max_last", 32'(a_last), 32'd0);
`else
      checkOutput("t1_max_last", 32'(a_last), 32'd1);
`endif
      applyStimulus(16'd7);
`ifdef MEM_REPORT_MIN_EN
      checkOutput("t1_min",      32'(a_data), 32'h2);
      checkOutput("t1_min_last", 32'(a_last), 32'd1);
`endif
      applyStimulus(16'd7);
      checkOutput("t1_idle", 32'(a_valid), 32'd0);
      applyStimulus(16'd7);
      checkOutput("t1_seq1_hdr", 32'(a_data), 32'h0000A501);

      // second window was all 7s, third all 1s: no leakage
      applyStimulus(16'd1);
      checkOutput("t2_win2_max", 32'(a_data), 32'h7);
      applyStimulus(16'd1);
`ifdef MEM_REPORT_MIN_EN
      checkOutput("t2_win2_min", 32'(a_data), 32'h7);
`endif
      applyStimulus(16'd1);
      applyStimulus(16'd1);
      checkOutput("t2_hdr", 32'(a_data), 32'h0000A502);
      applyStimulus(16'd0);
      checkOutput("t2_win3_max", 32'(a_data), 32'h1);

      a_en = 1'b0;
      repeat (4) applyStimulus(16'd0);
      checkOutput("drain_idle", 32'(a_valid), 32'd0);

      // stall long enough to overflow the drop counter
      a_en = 1'b1;
      repeat (4) applyStimulus(16'd20);
      checkOutput("t4_hdr", 32'(a_data), 32'h0000A503);
      a_ready = 1'b0;
      repeat (4) applyStimulus(16'd20);
      checkOutput("t4_drop1", 32'(a_drop), 32'd1);
      repeat (1100) applyStimulus(16'd20);
      checkOutput("t4_drop_sat",   32'(a_drop),  32'd255);
      checkOutput("t4_hdr_stable", 32'(a_data),  32'h0000A503);
      checkOutput("t4_valid_held", 32'(a_valid), 32'd1);

      // reset while MAX is stalled
      a_ready = 1'b1;
      applyStimulus(16'd20);
      checkOutput("t5_max", 32'(a_data), 32'h14);
      a_ready = 1'b0;
      repeat (2) applyStimulus(16'd20);
      checkOutput("t5_max_stable", 32'(a_data), 32'h14);
      reset = 1'b1;
      applyStimulus(16'd0);
      checkOutput("t5_rst_valid", 32'(a_valid), 32'd0);
      checkOutput("t5_rst_drop",  32'(a_drop),  32'd0);
      checkOutput("t5_rst_last",  32'(a_last),  32'd0);
      reset = 1'b0;

      // window_en dropped mid-window; only post-enable samples count
      a_ready = 1'b1;
      applyStimulus(16'd50);
      applyStimulus(16'd50);
      a_en = 1'b0;
      repeat (10) applyStimulus(16'd200);
      checkOutput("t6_disabled_idle", 32'(a_valid), 32'd0);
      a_en = 1'b1;
      applyStimulus(16'd4);
      applyStimulus(16'd6);
      applyStimulus(16'd5);
      checkOutput("t6_not_yet", 32'(a_valid), 32'd0);
      applyStimulus(16'd3);
      checkOutput("t6_hdr_valid", 32'(a_valid), 32'd1);
      checkOutput("t6_hdr",       32'(a_data),  32'h0000A500);
      applyStimulus(16'd0);
      checkOutput("t6_max", 32'(a_data), 32'h6);
`ifdef MEM_REPORT_MIN_EN
      applyStimulus(16'd0);
      checkOutput("t6_min", 32'(a_data), 32'h3);
`endif
      a_en = 1'b0;

      // 1024-cycle windows under sustained back-pressure
      b_en = 1'b1;
      b_ready = 1'b0;
      for (int i = 0; i < 3100; i++) begin
         if (i == 10)
            b_usage = 16'd777;
         else if (i < 1024)
            b_usage = 16'(100 + (i % 50));
         else
            b_usage = 16'd900;
         tick();
         if (i == 1023) begin
            checkOutput("t3_hdr_valid", 32'(b_valid), 32'd1);
            checkOutput("t3_hdr",       32'(b_data),  32'h0000A500);
         end
      end
      checkOutput("t3_drop",       32'(b_drop),  32'd2);
      checkOutput("t3_hdr_stable", 32'(b_data),  32'h0000A500);
      checkOutput("t3_hdr_last",   32'(b_last),  32'd0);
      b_ready = 1'b1;
      tick();
      checkOutput("t3_max", 32'(b_data), 32'd777);
      tick();
`ifdef MEM_REPORT_MIN_EN
      checkOutput("t3_min",      32'(b_data), 32'd100);
      checkOutput("t3_min_last", 32'(b_last), 32'd1);
`endif
      tick();
      checkOutput("t3_idle", 32'(b_valid), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
